// File: rtl/light_package.sv
// light_package: lamp colours, sequencer states and counter sizing for the phase sequencer
package light_package;
  typedef enum logic [1:0] {red, yellow, green} colors;
  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} tlc_state_t;
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    m = m > d ? m : d;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/tlc_rr_arbiter.sv
// tlc_rr_arbiter: rotating-priority find-first, scanning upward from the phase after last
module tlc_rr_arbiter #(
  parameter int NUM_PHASES = 5
) (
  input  logic [NUM_PHASES-1:0]         req,
  input  logic [$clog2(NUM_PHASES)-1:0] last,
  output logic [$clog2(NUM_PHASES)-1:0] grant_idx,
  output logic                          grant_vld
);
  localparam int IW = $clog2(NUM_PHASES);
  logic [IW-1:0] k;
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    k = '0;
    // walk from the farthest candidate down so the nearest requester after last wins
    for (int i = NUM_PHASES; i >= 1; i--) begin
      k = IW'((int'(last) + i) % NUM_PHASES);
      if (req[k]) begin
        grant_idx = k;
        grant_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tlc_phase_sequencer.sv
// tlc_phase_sequencer: round-robin green/yellow/all-red sequencer; TLC_PREEMPT_EN adds preemption
module tlc_phase_sequencer
  import light_package::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int GAP_CYC    = 5,
  parameter int MAX_CYC    = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PHASES-1:0]         sensor,
`ifdef TLC_PREEMPT_EN
  input  logic                          preempt,
  input  logic [$clog2(NUM_PHASES)-1:0] preempt_phase,
`endif
  output colors [NUM_PHASES-1:0]        light,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          phase_valid
);
  localparam int IW = $clog2(NUM_PHASES);
  localparam int CW = cnt_width(GAP_CYC, MAX_CYC, YELLOW_CYC, ALLRED_CYC);
  tlc_state_t state_q, state_d;
  logic [IW-1:0] cur_q, cur_d, last_q, last_d, grant_idx, pre_phase;
  logic [CW-1:0] tmr_q, tmr_d, gap_q, gap_d, max_q, max_d;
  logic grant_vld, conflict, pre_arb, pre_cut, pre_hold;
  tlc_rr_arbiter #(.NUM_PHASES(NUM_PHASES)) u_arb (
    .req(sensor),
    .last(last_q),
    .grant_idx(grant_idx),
    .grant_vld(grant_vld)
  );
`ifdef TLC_PREEMPT_EN
  assign pre_arb   = preempt;
  assign pre_cut   = preempt && cur_q != preempt_phase;
  assign pre_hold  = preempt && cur_q == preempt_phase;
  assign pre_phase = preempt_phase;
`else
  assign pre_arb   = 1'b0;
  assign pre_cut   = 1'b0;
  assign pre_hold  = 1'b0;
  assign pre_phase = '0;
`endif
  assign conflict = |(sensor & ~(NUM_PHASES'(1) << cur_q));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ALLRED;
      cur_q   <= '0;
      last_q  <= IW'(NUM_PHASES - 1);
      tmr_q   <= '0;
      gap_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
      max_q   <= max_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    tmr_d   = tmr_q;
    gap_d   = gap_q;
    max_d   = max_q;
    case (state_q)
      ALLRED: begin
        if (tmr_q != CW'(ALLRED_CYC - 1)) tmr_d = tmr_q + CW'(1);
        else if (pre_arb) begin
          state_d = GREEN;
          cur_d   = pre_phase;
          tmr_d   = '0;
        end else if (grant_vld) begin
          state_d = GREEN;
          cur_d   = grant_idx;
          last_d  = grant_idx;
          tmr_d   = '0;
        end
      end
      GREEN: begin
        if (pre_cut || gap_q == CW'(GAP_CYC - 1) || max_q == CW'(MAX_CYC - 1)) begin
          state_d = YELLOW;
          gap_d   = '0;
          max_d   = '0;
        end else if (pre_hold) begin
          gap_d = '0;
          max_d = '0;
        end else begin
          // once started, each timer runs regardless of later sensor changes
          gap_d = (gap_q != '0 || !sensor[cur_q]) ? gap_q + CW'(1) : '0;
          max_d = (max_q != '0 || conflict) ? max_q + CW'(1) : '0;
        end
      end
      YELLOW: begin
        state_d = tmr_q == CW'(YELLOW_CYC - 1) ? ALLRED : YELLOW;
        tmr_d   = tmr_q == CW'(YELLOW_CYC - 1) ? '0 : tmr_q + CW'(1);
      end
      default: state_d = ALLRED;
    endcase
  end
  always_comb begin
    for (int p = 0; p < NUM_PHASES; p++) light[p] = red;
    if (state_q == GREEN) light[cur_q] = green;
    else if (state_q == YELLOW) light[cur_q] = yellow;
    phase_valid  = state_q != ALLRED;
    active_phase = phase_valid ? cur_q : '0;
  end
endmodule
